vga_timing_ctrl: RTL and testbench

//  Sequences the VGA pixel datapath: generates pixel strobe, col/row scan counters, output_valid
//  and hsync/vsync for a fixed video mode. Sits between the system clock and the colour generator,

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/pixel_tick_div.sv | 46 ++++
 rtl/vga_timing_ctrl.sv | 133 +++++++++++++
 tb/tb_vga_timing_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Default 640x480@60 mode constants and scan state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

    localparam int COORD_W = 11;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam bit SYNC_ACTIVE_LOW = 1'b0;

    // PARKED: held at (0,0) waiting for the first pixel tick after reset or en=0.
    typedef enum logic [0:0] {
        SCAN_PARKED = 1'b0,
        SCAN_RUN    = 1'b1
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_tick_div.sv
// ============================================================================
//  Module      : pixel_tick_div
//  Description : Divides clk by CLK_DIV into a pixel-advance strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick_next,
    output logic pix_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;

    // Combinational so the scan counters can load on the same edge pix_tick rises.
    assign tick_next = en && (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_tick <= 1'b0;
        end else begin
            pix_tick <= tick_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
// ============================================================================
//  Module      : vga_timing_ctrl
//  Description : VGA scan counters, sync/valid decode and strobes, all registered.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [10:0]  col,
    output logic [10:0]  row,
    output logic         output_valid,
    output logic         hsync,
    output logic         vsync,
    output logic         pix_tick,
    output logic         line_start,
    output logic         frame_start
);

    localparam int LINE_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(LINE_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(FRAME_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
    localparam logic SYNC_ON  = SYNC_POL;
    localparam logic SYNC_OFF = !SYNC_POL;

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [COORD_W-1:0] w_col_nxt;
    logic [COORD_W-1:0] w_row_nxt;
    logic               w_load;
    logic               w_tick_next;
    logic               w_h_act;
    logic               w_v_act;
    logic               w_vis;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .tick_next (w_tick_next),
        .pix_tick  (pix_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SCAN_PARKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The first tick out of PARKED lands on (0,0) so the frame opens with frame_start.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = col;
        w_row_nxt   = row;
        w_load      = 1'b0;
        if (!en) begin
            w_state_nxt = SCAN_PARKED;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
            w_load      = 1'b1;
        end else if (w_tick_next) begin
            w_state_nxt = SCAN_RUN;
            w_load      = 1'b1;
            if (r_state == SCAN_PARKED) begin
                w_col_nxt = '0;
                w_row_nxt = '0;
            end else if (col == H_LAST) begin
                w_col_nxt = '0;
                w_row_nxt = (row == V_LAST) ? '0 : row + ONE;
            end else begin
                w_col_nxt = col + ONE;
            end
        end
    end

    // Decode from next-state so every registered output describes the same pixel.
    assign w_h_act = (w_col_nxt >= HS_START) && (w_col_nxt < HS_END);
    assign w_v_act = (w_row_nxt >= VS_START) && (w_row_nxt < VS_END);
    assign w_vis   = (w_col_nxt < H_VIS) && (w_row_nxt < V_VIS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col          <= '0;
            row          <= '0;
            output_valid <= 1'b0;
            hsync        <= SYNC_OFF;
            vsync        <= SYNC_OFF;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            line_start  <= w_tick_next && (w_col_nxt == '0);
            frame_start <= w_tick_next && (w_col_nxt == '0) && (w_row_nxt == '0);
            if (w_load) begin
                col          <= w_col_nxt;
                row          <= w_row_nxt;
                output_valid <= en && w_vis;
                hsync        <= (en && w_h_act) ? SYNC_ON : SYNC_OFF;
                vsync        <= (en && w_v_act) ? SYNC_ON : SYNC_OFF;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
// ============================================================================
//  Module      : tb_vga_timing_ctrl
//  Description : Three-mode bench for vga_timing_ctrl against an arithmetic scan model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vga_timing_ctrl;

    typedef struct packed {
        logic [10:0] col;
        logic [10:0] row;
        logic        valid;
        logic        hsync;
        logic        vsync;
        logic        pix_tick;
        logic        line_start;
        logic        frame_start;
    } obs_t;

    typedef struct {
        int div, ha, hfp, hs, hbp, va, vfp, vs, vbp;
        bit pol;
    } cfg_t;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [10:0] col   [NI];
    logic [10:0] row   [NI];
    logic        valid [NI];
    logic        hsync [NI];
    logic        vsync [NI];
    logic        tick  [NI];
    logic        ls    [NI];
    logic        fs    [NI];

    cfg_t  cfg   [NI];
    string name  [NI];
    int    n_clk [NI];
    int    cyc = 0;
    int    compared = 0;
    int    mismatched = 0;

    always #5 clk = ~clk;

    vga_timing_ctrl u_def (
        .clk(clk), .rst_n(rst_n), .en(en),
        .col(col[0]), .row(row[0]), .output_valid(valid[0]),
        .hsync(hsync[0]), .vsync(vsync[0]), .pix_tick(tick[0]),
        .line_start(ls[0]), .frame_start(fs[0])
    );

    vga_timing_ctrl #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .en(en),
        .col(col[1]), .row(row[1]), .output_valid(valid[1]),
        .hsync(hsync[1]), .vsync(vsync[1]), .pix_tick(tick[1]),
        .line_start(ls[1]), .frame_start(fs[1])
    );

    vga_timing_ctrl #(
        .CLK_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
    ) u_med (
        .clk(clk), .rst_n(rst_n), .en(en),
        .col(col[2]), .row(row[2]), .output_valid(valid[2]),
        .hsync(hsync[2]), .vsync(vsync[2]), .pix_tick(tick[2]),
        .line_start(ls[2]), .frame_start(fs[2])
    );

    // n = clocks with en=1 since the last reset/park; pixel ticks fall on multiples of div.
    function automatic obs_t model(input cfg_t c, input int n);
        obs_t o;
        int ht, vt, t, p, cl, rw, hs0, vs0;
        ht  = c.ha + c.hfp + c.hs + c.hbp;
        vt  = c.va + c.vfp + c.vs + c.vbp;
        hs0 = c.ha + c.hfp;
        vs0 = c.va + c.vfp;
        o.col = '0;
        o.row = '0;
        o.valid = 1'b0;
        o.hsync = !c.pol;
        o.vsync = !c.pol;
        o.pix_tick = 1'b0;
        o.line_start = 1'b0;
        o.frame_start = 1'b0;
        t = n / c.div;
        if (t > 0) begin
            p  = (t - 1) % (ht * vt);
            cl = p % ht;
            rw = p / ht;
            o.col = 11'(cl);
            o.row = 11'(rw);
            o.valid = (cl < c.ha) && (rw < c.va);
            o.hsync = (cl >= hs0 && cl < hs0 + c.hs) ? c.pol : !c.pol;
            o.vsync = (rw >= vs0 && rw < vs0 + c.vs) ? c.pol : !c.pol;
            o.pix_tick = (n % c.div) == 0;
            o.line_start = o.pix_tick && (cl == 0);
            o.frame_start = o.pix_tick && (p == 0);
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic step(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            for (int i = 0; i < NI; i++)
                n_clk[i] = (!rst_n || !en) ? 0 : n_clk[i] + 1;
            cyc++;
            #1;
            for (int i = 0; i < NI; i++) begin
                obs_t o;
                obs_t e;
                o = {col[i], row[i], valid[i], hsync[i], vsync[i], tick[i], ls[i], fs[i]};
                e = model(cfg[i], n_clk[i]);
                check($sformatf("%s_scan@%0d", name[i], cyc), 64'(o), 64'(e));
            end
        end
    endtask

    initial begin
        cfg[0]  = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
        cfg[1]  = '{1, 8, 1, 2, 1, 4, 1, 1, 1, 1'b0};
        cfg[2]  = '{3, 20, 3, 5, 4, 6, 2, 2, 3, 1'b1};
        name[0] = "def";
        name[1] = "small";
        name[2] = "med";
        for (int i = 0; i < NI; i++) n_clk[i] = 0;

        // Reset held three clocks: parked outputs, default syncs idle high.
        rst_n = 1'b0;
        en    = 1'b0;
        step(3);
        check("def_reset_hsync", 64'(hsync[0]), 64'(1));
        check("def_reset_vsync", 64'(vsync[0]), 64'(1));

        // Free run: two full default lines plus up to col 700 of row 2.
        rst_n = 1'b1;
        en    = 1'b1;
        step(2);
        check("def_first_frame_start", 64'(fs[0]), 64'(1));
        step(1600 * 2 + 1402 - 2);
        check("def_col_at_pulse", 64'(col[0]), 64'(700));
        check("def_hsync_mid_pulse", 64'(hsync[0]), 64'(0));

        // One-clock reset mid-hsync, then clean restart.
        rst_n = 1'b0;
        step(1);
        check("def_hsync_after_rst", 64'(hsync[0]), 64'(1));
        rst_n = 1'b1;
        step(2000);

        // Scan enable dropped for one clock.
        en = 1'b0;
        step(1);
        check("def_valid_parked", 64'(valid[0]), 64'(0));
        en = 1'b1;
        step(800);

        // Random runs interrupted by short reset or enable drops.
        for (int k = 0; k < 60; k++) begin
            step($urandom_range(20, 200));
            if ($urandom_range(0, 3) == 0) rst_n = 1'b0;
            else                          en    = 1'b0;
            step($urandom_range(1, 4));
            rst_n = 1'b1;
            en    = 1'b1;
        end
        step(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
